// File: rtl/board_video_gen.sv
// board_video_gen: draws a ROWS x COLS board of square cells with frame gaps,
// colours each cell from an internal 2-bit state memory and outlines the cursor
// cell with a blinking border. Fixed 2-cycle pixel pipeline.
// Optional feature macro: CURSOR_BLINK_EN (defined = outline blinks every
// BLINK_FRAMES frame_tick pulses; undefined = outline always drawn).
module board_video_gen #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CELL         = 56,
  parameter int FRAME        = 4,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int BORDER       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       frame_tick,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [1:0] wr_state,
  input  logic [2:0] cur_row,
  input  logic [2:0] cur_col,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int PITCH = CELL + FRAME;

  localparam logic [10:0] PITCH_W  = 11'(PITCH);
  localparam logic [10:0] CELL_W   = 11'(CELL);
  localparam logic [10:0] BORD_W   = 11'(BORDER);
  localparam logic [10:0] INNER_W  = 11'(CELL - BORDER);
  localparam logic [10:0] COLS_W   = 11'(COLS);
  localparam logic [10:0] ROWS_W   = 11'(ROWS);
  localparam logic [3:0]  ROWS_N   = 4'(ROWS);
  localparam logic [3:0]  COLS_N   = 4'(COLS);

  localparam logic [23:0] C_BLACK  = 24'h000000;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_EMPTY  = 24'h006000;
  localparam logic [23:0] C_PLAYA  = 24'hFF0000;
  localparam logic [23:0] C_PLAYB  = 24'h0000FF;
  localparam logic [23:0] C_HILITE = 24'hFFFF00;

  // cell state memory
  logic [1:0] cells [ROWS][COLS];

  // stage 1 combinational geometry
  logic signed [10:0] lx, ly;
  logic [10:0] lx_u, ly_u;
  logic [10:0] col_c, row_c;
  logic [10:0] ox_c, oy_c;
  logic        onboard_c, incell_c, edge_c, iscur_c;
  logic [2:0]  rd_row, rd_col;
  logic [1:0]  cell_c;
  logic        wr_ok;

  // stage 1 registers
  logic       s1_incell, s1_edge, s1_iscur;
  logic [1:0] s1_state;

  logic       phase;

  assign lx   = $signed({1'b0, x}) - $signed(11'(X0));
  assign ly   = $signed({1'b0, y}) - $signed(11'(Y0));
  assign lx_u = lx;
  assign ly_u = ly;

  // divide by a constant pitch; negative offsets are masked by onboard_c
  assign col_c = lx_u / PITCH_W;
  assign row_c = ly_u / PITCH_W;
  assign ox_c  = lx_u - col_c * PITCH_W;
  assign oy_c  = ly_u - row_c * PITCH_W;

  assign onboard_c = active & ~lx[10] & ~ly[10] & (col_c < COLS_W) & (row_c < ROWS_W);
  assign incell_c  = onboard_c & (ox_c < CELL_W) & (oy_c < CELL_W);
  assign edge_c    = incell_c & ((ox_c < BORD_W) | (oy_c < BORD_W) |
                                 (ox_c >= INNER_W) | (oy_c >= INNER_W));
  // an out-of-range cursor can never match an on-board cell, so no outline is drawn
  assign iscur_c   = (row_c == {8'd0, cur_row}) & (col_c == {8'd0, cur_col});

  // keep the memory index in range when the pixel is off the board
  assign rd_row = onboard_c ? row_c[2:0] : 3'd0;
  assign rd_col = onboard_c ? col_c[2:0] : 3'd0;
  // read happens in stage 1, so a same-cycle write is not yet visible
  assign cell_c = cells[rd_row][rd_col];

  assign wr_ok = ({1'b0, wr_row} < ROWS_N) & ({1'b0, wr_col} < COLS_N);

  // cell memory: clear beats write, out-of-range writes dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          cells[i][j] <= 2'd0;
    end else if (clear) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          cells[i][j] <= 2'd0;
    end else if (wr_en && wr_ok) begin
      cells[wr_row][wr_col] <= wr_state;
    end
  end

  // stage 1: register geometry flags and the cell state under the pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_incell <= 1'b0;
      s1_edge   <= 1'b0;
      s1_iscur  <= 1'b0;
      s1_state  <= 2'd0;
    end else begin
      s1_incell <= incell_c;
      s1_edge   <= edge_c;
      s1_iscur  <= iscur_c;
      s1_state  <= cell_c;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;

  // blink counter: counts frame_tick cycles, toggles phase on wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = frame_tick;
  assign phase       = 1'b1;
`endif

  // stage 2: colour select in priority order, registered to the DAC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r, g, b} <= C_BLACK;
    end else if (!s1_incell) begin
      {r, g, b} <= C_BLACK;
    end else if (s1_iscur && s1_edge && phase) begin
      {r, g, b} <= C_WHITE;
    end else begin
      case (s1_state)
        2'd0:    {r, g, b} <= C_EMPTY;
        2'd1:    {r, g, b} <= C_PLAYA;
        2'd2:    {r, g, b} <= C_PLAYB;
        default: {r, g, b} <= C_HILITE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_video_gen.sv
module tb_board_video_gen;

  localparam int ROWS = 8, COLS = 8, CELL = 56, FRAME = 4, PITCH = 60;
  localparam int X0 = 0, Y0 = 0, BORDER = 2, BLINK = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       active, frame_tick, clear, wr_en;
  logic [2:0] wr_row, wr_col, cur_row, cur_col;
  logic [1:0] wr_state;
  logic [7:0] r, g, b;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_cells [ROWS][COLS];
  int ticks;

  board_video_gen dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .frame_tick(frame_tick),
    .clear(clear), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_state(wr_state),
    .cur_row(cur_row), .cur_col(cur_col), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] palette(int s);
    case (s)
      0: return 24'h006000;
      1: return 24'hFF0000;
      2: return 24'h0000FF;
      default: return 24'hFFFF00;
    endcase
  endfunction

  function automatic bit model_phase();
`ifdef CURSOR_BLINK_EN
    return ((ticks / BLINK) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // colour of a pixel from the board geometry, using plain arithmetic
  function automatic logic [23:0] model_rgb(int px, int py, bit act, int crow, int ccol);
    int lx, ly, c, rw, ox, oy;
    bit on_edge;
    lx = px - X0;
    ly = py - Y0;
    if (!act || lx < 0 || ly < 0) return 24'h0;
    c  = lx / PITCH;  rw = ly / PITCH;
    ox = lx % PITCH;  oy = ly % PITCH;
    if (c >= COLS || rw >= ROWS || ox >= CELL || oy >= CELL) return 24'h0;
    on_edge = (ox < BORDER) || (oy < BORDER) || (ox >= CELL - BORDER) || (oy >= CELL - BORDER);
    if (rw == crow && c == ccol && on_edge && model_phase()) return 24'hFFFFFF;
    return palette(m_cells[rw][c]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [23:0] got, logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", nm, got, exp);
    end
  endtask

  task automatic pixel(int px, int py, bit act);
    x = 10'(px); y = 10'(py); active = act;
    step();
    step();
  endtask

  task automatic write_cell(int rw, int c, int s);
    wr_en = 1'b1; wr_row = 3'(rw); wr_col = 3'(c); wr_state = 2'(s);
    step();
    wr_en = 1'b0;
    m_cells[rw][c] = s;
  endtask

  task automatic model_clear();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        m_cells[i][j] = 0;
  endtask

  typedef struct {
    int          px;
    int          py;
    bit          act;
    logic [23:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs [6];
  logic [23:0] exp_q [$];
  logic [23:0] e;

  initial begin
    vecs[0] = '{0,   0,   1'b1, 24'h006000, "empty_cell_00"};
    vecs[1] = '{56,  0,   1'b1, 24'h000000, "frame_gap_x56"};
    vecs[2] = '{10,  58,  1'b1, 24'h000000, "frame_gap_y58"};
    vecs[3] = '{480, 10,  1'b1, 24'h000000, "off_board_col8"};
    vecs[4] = '{10,  10,  1'b0, 24'h000000, "blanking"};
    vecs[5] = '{59,  59,  1'b1, 24'h000000, "gap_corner"};

    rst = 1'b1; x = '0; y = '0; active = 1'b0; frame_tick = 1'b0; clear = 1'b0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_state = '0; cur_row = 3'd7; cur_col = 3'd7;
    model_clear();
    ticks = 0;
    #23;
    check("reset_rgb", {r, g, b}, 24'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // table-driven single pixels, cursor parked away at (7,7)
    foreach (vecs[i]) begin
      pixel(vecs[i].px, vecs[i].py, vecs[i].act);
      check(vecs[i].nm, {r, g, b}, vecs[i].exp);
    end

    // write then read back
    write_cell(2, 3, 1);
    pixel(190, 130, 1'b1);
    check("write_player_a", {r, g, b}, 24'hFF0000);

    // same-cycle write and read of (0,0): old colour first
    x = 10'd0; y = 10'd0; active = 1'b1;
    wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_state = 2'd2;
    step();
    wr_en = 1'b0;
    step();
    check("same_cycle_old", {r, g, b}, 24'h006000);
    m_cells[0][0] = 2;
    pixel(0, 0, 1'b1);
    check("next_read_new", {r, g, b}, 24'h0000FF);

    // cursor outline and blink
    clear = 1'b1; step(); clear = 1'b0; model_clear();
    cur_row = 3'd0; cur_col = 3'd0;
    pixel(0, 0, 1'b1);   check("cursor_corner", {r, g, b}, 24'hFFFFFF);
    pixel(1, 30, 1'b1);  check("cursor_left_edge", {r, g, b}, 24'hFFFFFF);
    pixel(10, 10, 1'b1); check("cursor_inside", {r, g, b}, 24'h006000);
    pixel(2, 30, 1'b1);  check("cursor_past_border", {r, g, b}, 24'h006000);
    pixel(54, 30, 1'b1); check("cursor_right_edge", {r, g, b}, 24'hFFFFFF);

    for (int i = 0; i < 29; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      ticks++;
    end
    pixel(0, 0, 1'b1);
    check("blink_29_ticks", {r, g, b}, model_rgb(0, 0, 1'b1, 0, 0));
    frame_tick = 1'b1; step(); frame_tick = 1'b0; ticks++;
    pixel(0, 0, 1'b1);
`ifdef CURSOR_BLINK_EN
    check("blink_30_off", {r, g, b}, 24'h006000);
`else
    check("blink_30_const", {r, g, b}, 24'hFFFFFF);
`endif
    frame_tick = 1'b1;
    for (int i = 0; i < 30; i++) step();
    frame_tick = 1'b0; ticks += 30;
    pixel(0, 0, 1'b1);
    check("blink_60_on", {r, g, b}, 24'hFFFFFF);

    // fill with state 3, then clear wins over a simultaneous write
    cur_row = 3'd7; cur_col = 3'd7;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        write_cell(i, j, 3);
    pixel(30 + 4 * PITCH, 30 + 5 * PITCH, 1'b1);
    check("filled_hilite", {r, g, b}, 24'hFFFF00);
    clear = 1'b1; wr_en = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_state = 2'd2;
    step();
    clear = 1'b0; wr_en = 1'b0; model_clear();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        pixel(j * PITCH + 28, i * PITCH + 28, 1'b1);
        check($sformatf("clear_cell_%0d_%0d", i, j), {r, g, b}, 24'h006000);
      end

    // asynchronous reset mid-line
    write_cell(2, 3, 1);
    x = 10'd190; y = 10'd130; active = 1'b1;
    step(); step();
    check("pre_reset_color", {r, g, b}, 24'hFF0000);
    #2 rst = 1'b1;
    #1 check("reset_immediate", {r, g, b}, 24'h0);
    model_clear(); ticks = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    pixel(190, 130, 1'b1);
    check("after_reset_empty", {r, g, b}, 24'h006000);

    // randomized pipelined stream against the reference model
    for (int i = 0; i < 3000; i++) begin
      x = 10'($urandom_range(0, 540));
      y = 10'($urandom_range(0, 540));
      active = ($urandom_range(0, 7) != 0);
      cur_row = 3'($urandom_range(0, 7));
      cur_col = 3'($urandom_range(0, 7));
      wr_en = ($urandom_range(0, 3) == 0);
      wr_row = 3'($urandom_range(0, 7));
      wr_col = 3'($urandom_range(0, 7));
      wr_state = 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 199) == 0);
      exp_q.push_back(model_rgb(int'(x), int'(y), active, int'(cur_row), int'(cur_col)));
      step();
      if (clear) model_clear();
      else if (wr_en) m_cells[wr_row][wr_col] = int'(wr_state);
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        check("random_stream", {r, g, b}, e);
      end
    end
    wr_en = 1'b0; clear = 1'b0;
    step();
    e = exp_q.pop_front();
    check("random_tail", {r, g, b}, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
